// File: rtl/pi_estimator_axi_pkg.sv
// Shared types and constants for the PiEstimator AXI4-Lite register slave.
//   - register select / bus widths
//   - FSM state encodings for the write and read channels
//   - latched write request payload
//   - byte_merge(): strobe-controlled merge of write data into a register
package pi_estimator_axi_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_SEL_W = 2;
  localparam int unsigned ADDR_LSB  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [REG_SEL_W-1:0] REG_CTRL = 2'd0;
  localparam logic [REG_SEL_W-1:0] REG_1    = 2'd1;
  localparam logic [REG_SEL_W-1:0] REG_2    = 2'd2;
  localparam logic [REG_SEL_W-1:0] REG_3    = 2'd3;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_HOLD = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // Write request assembled from independently arriving AW and W beats
  typedef struct packed {
    logic [REG_SEL_W-1:0] sel;
    logic [DATA_W-1:0]    data;
    logic [STRB_W-1:0]    strb;
  } wr_req_t;

  // Replace only the bytes whose strobe bit is set
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/pi_estimator_axi_slave.sv
// AXI4-Lite slave holding four 32-bit control registers for the PiEstimator core.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, data and response channels
//   S_AXI_AR* / S_AXI_R*             read address and data channels
//   slv_reg0..slv_reg3               register contents to the estimator core
//   reg_wr_pulse                     one-cycle pulse on the register committed
module pi_estimator_axi_slave
  import pi_estimator_axi_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
  output logic [3:0]                      reg_wr_pulse
);

  // Register file and registered channel outputs
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  wr_state_e           r_wr_state;
  rd_state_e           r_rd_state;
  wr_req_t             r_wr_req;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic                r_arready;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [NUM_REGS-1:0] r_wr_pulse;

  // Next-state values
  wr_state_e           w_wr_state_nxt;
  rd_state_e           w_rd_state_nxt;
  wr_req_t             w_wr_req_nxt;
  logic                w_aw_done_nxt;
  logic                w_w_done_nxt;
  logic                w_awready_nxt;
  logic                w_wready_nxt;
  logic                w_bvalid_nxt;
  logic                w_arready_nxt;
  logic                w_rvalid_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic [NUM_REGS-1:0] w_wr_pulse_nxt;
  logic                w_commit;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic [REG_SEL_W-1:0] w_rd_sel;

  // Protection bits and the byte-offset address bits carry no meaning here
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID  & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  assign w_rd_sel = S_AXI_ARADDR[ADDR_LSB +: REG_SEL_W];

  // Write FSM: collect AW and W in any order, commit one edge after both are held
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_req_nxt   = r_wr_req;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_bvalid_nxt   = r_bvalid;
    w_commit       = 1'b0;
    unique case (r_wr_state)
      WR_IDLE, WR_HOLD: begin
        if ((r_wr_state == WR_HOLD) && r_aw_done && r_w_done) begin
          w_commit       = 1'b1;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_bvalid_nxt   = 1'b1;
          w_wr_state_nxt = WR_RESP;
        end else begin
          if (w_aw_hs) begin
            w_aw_done_nxt    = 1'b1;
            w_wr_req_nxt.sel = S_AXI_AWADDR[ADDR_LSB +: REG_SEL_W];
          end
          if (w_w_hs) begin
            w_w_done_nxt      = 1'b1;
            w_wr_req_nxt.data = DATA_W'(S_AXI_WDATA);
            w_wr_req_nxt.strb = STRB_W'(S_AXI_WSTRB);
          end
          if (w_aw_hs || w_w_hs) begin
            w_wr_state_nxt = WR_HOLD;
          end
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          w_bvalid_nxt   = 1'b0;
          w_wr_state_nxt = WR_IDLE;
        end
      end
      default: begin
        w_wr_state_nxt = WR_IDLE;
      end
    endcase
    // Each channel stays open until its own beat has been captured
    w_awready_nxt  = (w_wr_state_nxt != WR_RESP) && !w_aw_done_nxt;
    w_wready_nxt   = (w_wr_state_nxt != WR_RESP) && !w_w_done_nxt;
    w_wr_pulse_nxt = w_commit ? (NUM_REGS'(1) << r_wr_req.sel) : '0;
  end

  // Read FSM: capture on AR handshake, hold until R handshake
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rvalid_nxt   = r_rvalid;
    w_rdata_nxt    = r_rdata;
    w_arready_nxt  = r_arready;
    unique case (r_rd_state)
      RD_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          // Register array is sampled before any same-edge commit lands
          w_rdata_nxt    = r_regs[w_rd_sel];
          w_rvalid_nxt   = 1'b1;
          w_arready_nxt  = 1'b0;
          w_rd_state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          w_rvalid_nxt   = 1'b0;
          w_arready_nxt  = 1'b1;
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: begin
        w_rd_state_nxt = RD_IDLE;
      end
    endcase
  end

  // State, channel outputs and register file
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
      r_wr_req   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_wr_req   <= w_wr_req_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_arready  <= w_arready_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_rdata    <= w_rdata_nxt;
      r_wr_pulse <= w_wr_pulse_nxt;
      if (w_commit) begin
        r_regs[r_wr_req.sel] <= byte_merge(r_regs[r_wr_req.sel], r_wr_req.data, r_wr_req.strb);
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_rdata);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign slv_reg0      = C_S_AXI_DATA_WIDTH'(r_regs[REG_CTRL]);
  assign slv_reg1      = C_S_AXI_DATA_WIDTH'(r_regs[REG_1]);
  assign slv_reg2      = C_S_AXI_DATA_WIDTH'(r_regs[REG_2]);
  assign slv_reg3      = C_S_AXI_DATA_WIDTH'(r_regs[REG_3]);
  assign reg_wr_pulse  = r_wr_pulse;

endmodule
